axi_lite_bridge: RTL and testbench

- Responder for the core's simple AXI-side data port (axi_rd_en/axi_wr_en/axi_addr/wr_data/wr_strobe in; axi_rd_data/axi_access_fault/axi_busy out).
- Converts each single-word core request into one AXI4-Lite master transaction toward the peripheral interconnect.
- Stalls the single-cycle core with axi_busy until the transaction completes.
- Sits between the core top level and the peripheral crossbar (GPIO, UART, timers).

---
 rtl/axi_lite_bridge.sv | 147 ++++++++++++++
 tb/tb_axi_lite_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_bridge.sv
// Single-word core data port to AXI4-Lite master bridge.
// One transaction in flight at a time; the core is stalled with axi_busy until the response returns.
module axi_lite_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT       = 3'b001
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      axi_rd_en,
  input  logic                      axi_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               axi_rd_data,
  output logic                      axi_access_fault,
  output logic                      axi_busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [31:0]               m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic [31:0]               r_rd_data;
  logic                      r_fault;
  logic                      r_aw_done;
  logic                      r_w_done;

  logic w_req;
  logic w_aw_hs;
  logic w_w_hs;

  assign w_req   = axi_rd_en | axi_wr_en;
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;

  // Valids derive from state and per-channel done flags, so async reset drops them at once
  assign m_arvalid = (r_state == S_RD_ADDR);
  assign m_rready  = (r_state == S_RD_DATA);
  assign m_awvalid = (r_state == S_WR_REQ) & ~r_aw_done;
  assign m_wvalid  = (r_state == S_WR_REQ) & ~r_w_done;
  assign m_bready  = (r_state == S_WR_RESP);

  assign m_araddr = r_addr;
  assign m_awaddr = r_addr;
  assign m_arprot = AXI_PROT;
  assign m_awprot = AXI_PROT;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;

  assign axi_rd_data      = r_rd_data;
  assign axi_access_fault = (r_state == S_DONE) & r_fault;

  always_comb begin
    axi_busy = 1'b0;
    case (r_state)
      S_IDLE:                                    axi_busy = w_req;
      S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP: axi_busy = 1'b1;
      default:                                   axi_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rd_data <= '0;
      r_fault   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr    <= axi_addr;
            r_wdata   <= wr_data;
            r_wstrb   <= wr_strobe;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (axi_rd_en && axi_wr_en) begin
              r_fault <= 1'b1;
              r_state <= S_DONE;
            end else if (axi_rd_en) begin
              r_fault <= 1'b0;
              r_state <= S_RD_ADDR;
            end else begin
              r_fault <= 1'b0;
              r_state <= S_WR_REQ;
            end
          end
        end
        S_RD_ADDR: begin
          if (m_arready) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (m_rvalid) begin
            r_rd_data <= m_rdata;
            r_fault   <= (m_rresp != 2'b00);
            r_state   <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // Handshakes completing in this very cycle count as done
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) r_state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            r_fault <= (m_bresp != 2'b00);
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_bridge.sv
// Directed bench for axi_lite_bridge: configurable-wait AXI-Lite slave, transaction-level model,
// per-cycle protocol/response checker and hand-computed latency/response expectations.
module tb_axi_lite_bridge;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_IL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axi_rd_en, axi_wr_en;
  logic [31:0] axi_addr, wr_data;
  logic [3:0]  wr_strobe;
  logic [31:0] axi_rd_data;
  logic        axi_access_fault, axi_busy;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  axi_lite_bridge #(.AXI_ADDR_WIDTH(32), .AXI_PROT(3'b001)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe),
    .axi_rd_data(axi_rd_data), .axi_access_fault(axi_access_fault), .axi_busy(axi_busy),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: each ready/response rises after a configured number of waiting cycles
  int s_ar_wait = 0, s_r_wait = 0, s_aw_wait = 0, s_w_wait = 0, s_b_wait = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = 2'b00;
  assign m_rdata = s_rdata;
  assign m_rresp = s_resp;
  assign m_bresp = s_resp;

  always @(negedge clk) begin
    if (m_arvalid) begin m_arready = (ar_cnt >= s_ar_wait); ar_cnt = m_arready ? 0 : ar_cnt + 1; end
    else begin m_arready = 1'b0; ar_cnt = 0; end
    if (m_awvalid) begin m_awready = (aw_cnt >= s_aw_wait); aw_cnt = m_awready ? 0 : aw_cnt + 1; end
    else begin m_awready = 1'b0; aw_cnt = 0; end
    if (m_wvalid) begin m_wready = (w_cnt >= s_w_wait); w_cnt = m_wready ? 0 : w_cnt + 1; end
    else begin m_wready = 1'b0; w_cnt = 0; end
    if (m_rready) begin m_rvalid = (r_cnt >= s_r_wait); r_cnt = m_rvalid ? 0 : r_cnt + 1; end
    else begin m_rvalid = 1'b0; r_cnt = 0; end
    if (m_bready) begin m_bvalid = (b_cnt >= s_b_wait); b_cnt = m_bvalid ? 0 : b_cnt + 1; end
    else begin m_bvalid = 1'b0; b_cnt = 0; end
  end

  // Transaction-level model of the request in flight
  int          e_kind = K_RD;
  logic [31:0] e_addr = '0, e_data = '0, e_rdata = '0, last_rd = '0;
  logic [3:0]  e_strb = '0;
  logic        e_fault = 1'b0;
  bit          req_active = 1'b0;
  int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [3:0]  seen_wstrb = '0;
  bit          p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("reset_quiet", {27'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'd0);
      p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
    end else begin
      if (m_arvalid) begin
        chk("arprot", {29'd0, m_arprot}, 32'd1);
        chk("araddr", m_araddr, e_addr);
        chk("ar_kind", e_kind, K_RD);
      end
      if (m_awvalid) begin
        chk("awprot", {29'd0, m_awprot}, 32'd1);
        chk("awaddr", m_awaddr, e_addr);
        chk("aw_kind", e_kind, K_WR);
      end
      if (m_wvalid) begin
        chk("wdata", m_wdata, e_data);
        chk("wstrb", {28'd0, m_wstrb}, {28'd0, e_strb});
        chk("w_kind", e_kind, K_WR);
      end
      if (p_ar) chk("ar_held", {31'd0, m_arvalid}, 32'd1);
      if (p_aw) chk("aw_held", {31'd0, m_awvalid}, 32'd1);
      if (p_w)  chk("w_held", {31'd0, m_wvalid}, 32'd1);
      if (!req_active)
        chk("idle_quiet", {27'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'd0);
      if (req_active && !axi_busy) begin
        chk("done_rdata", axi_rd_data, e_rdata);
        chk("done_fault", {31'd0, axi_access_fault}, {31'd0, e_fault});
        chk("done_n_ar", n_ar, (e_kind == K_RD) ? 1 : 0);
        chk("done_n_r", n_r, (e_kind == K_RD) ? 1 : 0);
        chk("done_n_aw", n_aw, (e_kind == K_WR) ? 1 : 0);
        chk("done_n_w", n_w, (e_kind == K_WR) ? 1 : 0);
        chk("done_n_b", n_b, (e_kind == K_WR) ? 1 : 0);
      end else begin
        chk("fault_low", {31'd0, axi_access_fault}, 32'd0);
      end
      if (m_arvalid && m_arready) n_ar++;
      if (m_rready && m_rvalid)   n_r++;
      if (m_awvalid && m_awready) n_aw++;
      if (m_wvalid && m_wready) begin n_w++; seen_wstrb = m_wstrb; end
      if (m_bready && m_bvalid)   n_b++;
      p_ar = m_arvalid && !m_arready;
      p_aw = m_awvalid && !m_awready;
      p_w  = m_wvalid && !m_wready;
    end
  end

  task automatic run_req(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int arw, input int rw, input int aww,
                         input int ww, input int bw, input logic [1:0] resp,
                         input logic [31:0] rdata, input int lit_lat);
    int lat;
    int mlat;
    @(posedge clk); #1;
    s_ar_wait = arw; s_r_wait = rw; s_aw_wait = aww; s_w_wait = ww; s_b_wait = bw;
    s_resp = resp; s_rdata = rdata;
    e_kind = kind; e_addr = addr; e_data = data; e_strb = strb;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    if (kind == K_RD) last_rd = rdata;
    e_rdata = last_rd;
    e_fault = (kind == K_IL) ? 1'b1 : (resp != 2'b00);
    if (kind == K_RD)      mlat = 3 + arw + rw;
    else if (kind == K_WR) mlat = 3 + ((aww > ww) ? aww : ww) + bw;
    else                   mlat = 1;
    axi_rd_en = (kind != K_WR); axi_wr_en = (kind != K_RD);
    axi_addr = addr; wr_data = data; wr_strobe = strb;
    req_active = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!axi_busy) break;
      lat++;
      if (lat > 100) begin
        tests++; fails++;
        $display("FAIL busy_timeout: still busy after %0d cycles, addr 0x%08h", lat, addr);
        break;
      end
    end
    chk("latency_model", lat, mlat);
    if (lit_lat >= 0) chk("latency_literal", lat, lit_lat);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    axi_rd_en = 1'b0; axi_wr_en = 1'b0;
    req_active = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    axi_rd_en = 1'b0; axi_wr_en = 1'b0; axi_addr = '0; wr_data = '0; wr_strobe = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_busy", {31'd0, axi_busy}, 32'd0);
    chk("reset_rdata", axi_rd_data, 32'd0);
    chk("reset_fault", {31'd0, axi_access_fault}, 32'd0);
    chk("reset_valids", {29'd0, m_arvalid, m_awvalid, m_wvalid}, 32'd0);

    run_req(K_RD, 32'h0000_0010, 32'd0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 3);
    chk("rd_zero_wait_data", axi_rd_data, 32'hDEAD_BEEF);
    chk("rd_zero_wait_fault", {31'd0, axi_access_fault}, 32'd0);

    run_req(K_WR, 32'h0000_0104, 32'h1234_5678, 4'b0011, 0, 0, 2, 0, 0, 2'b00, 32'd0, 5);
    chk("wr_skew_wstrb", {28'd0, seen_wstrb}, 32'h3);
    chk("wr_skew_rdata_kept", axi_rd_data, 32'hDEAD_BEEF);
    chk("wr_skew_fault", {31'd0, axi_access_fault}, 32'd0);

    run_req(K_RD, 32'h0000_0020, 32'd0, 4'h0, 1, 2, 0, 0, 0, 2'b10, 32'hCAFE_0001, 6);
    chk("rd_slverr_fault", {31'd0, axi_access_fault}, 32'd1);

    run_req(K_WR, 32'h0000_0030, 32'hA5A5_A5A5, 4'b1111, 0, 0, 0, 3, 1, 2'b11, 32'd0, 7);
    chk("wr_decerr_fault", {31'd0, axi_access_fault}, 32'd1);
    chk("wr_decerr_rdata_kept", axi_rd_data, 32'hCAFE_0001);

    run_req(K_RD, 32'h0000_0040, 32'd0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1111_2222, 3);
    chk("after_err_fault", {31'd0, axi_access_fault}, 32'd0);
    run_req(K_WR, 32'h0000_0044, 32'h3333_4444, 4'b1100, 0, 0, 1, 1, 0, 2'b00, 32'd0, 4);
    chk("b2b_wr_fault", {31'd0, axi_access_fault}, 32'd0);

    run_req(K_IL, 32'h0000_0050, 32'h5555_AAAA, 4'b0101, 0, 0, 0, 0, 0, 2'b00, 32'd0, 1);
    chk("illegal_fault", {31'd0, axi_access_fault}, 32'd1);
    chk("illegal_rdata_kept", axi_rd_data, 32'h1111_2222);
    go_idle(3);

    // Reset while the write address is still waiting for awready
    @(posedge clk); #1;
    s_aw_wait = 10; s_w_wait = 10; s_b_wait = 0;
    e_kind = K_WR; e_addr = 32'h0000_0070; e_data = 32'h7777_0000; e_strb = 4'hF;
    axi_rd_en = 1'b0; axi_wr_en = 1'b1;
    axi_addr = 32'h0000_0070; wr_data = 32'h7777_0000; wr_strobe = 4'hF;
    req_active = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_awvalid && k < 10);
    chk("rst_mid_awvalid_up", {31'd0, m_awvalid}, 32'd1);
    #1 rst_n = 1'b0;
    req_active = 1'b0;
    axi_wr_en = 1'b0;
    last_rd = '0;
    #1;
    chk("rst_mid_valids_low", {29'd0, m_arvalid, m_awvalid, m_wvalid}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_busy", {31'd0, axi_busy}, 32'd0);
    chk("rst_mid_rdata", axi_rd_data, 32'd0);
    chk("rst_mid_fault", {31'd0, axi_access_fault}, 32'd0);

    run_req(K_RD, 32'h0000_0060, 32'd0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h00C0_FFEE, 3);
    chk("post_rst_rdata", axi_rd_data, 32'h00C0_FFEE);
    chk("post_rst_fault", {31'd0, axi_access_fault}, 32'd0);
    go_idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
